pio_write_arbiter: RTL
======================

# pio_write_arbiter

Round-robin write arbiter that shares one Avalon-MM output-PIO slave (17-bit `out_port`, data/set/clear registers) between several hardware requesters. Each requester asks for a full write, bit-set or bit-clear. The block serialises the requests into single-cycle slave writes and keeps a shadow copy of the PIO output so requesters never need to read back. It sits between the requester logic and the PIO `s1` port, alongside the Nios data master.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 17: PIO port width; must match the slave.

Ports:
- `clk`  in  1: single clock, shared with the PIO slave.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NREQ: per-requester request; held high until the matching `ack`.
- `req_op`  in  2×NREQ: per-requester operation. 00 = write, 01 = set, 10 = clear, 11 = reserved.
- `req_data`  in  DATA_W×NREQ: per-requester data or bit mask.
- `ack`  out  NREQ: one-cycle completion pulse, one-hot.
- `err`  out  1: one-cycle pulse with `ack` when the granted op is 11.
- `m_address`  out  3: PIO address.
- `m_chipselect`  out  1: PIO chip select.
- `m_write_n`  out  1: PIO write strobe, active-low.
- `m_writedata`  out  32: `{(32-DATA_W)'b0, data}`.
- `shadow`  out  DATA_W: current PIO output value as written by this block.

## Operation
- FSM states:
  - IDLE: bus inactive. If any `req` is high, select a winner, latch its index, op and data, and go to WRITE.
  - WRITE: drive exactly one write cycle, then return to IDLE.
- Arbitration: round-robin from pointer `ptr`. The winner is the first `req` bit at or above `ptr`, wrapping modulo NREQ. In WRITE, `ptr` becomes `winner+1` (mod NREQ).
- Address map: write → 0, set → 4, clear → 5.
- Shadow update in WRITE:
  - write: `shadow <= data`.
  - set: `shadow <= shadow | data`.
  - clear: `shadow <= shadow & ~data`.
- Reserved op 11: WRITE cycle keeps `m_chipselect`=0 and `shadow` unchanged. `ack` and `err` still pulse.
- Request rules:
  - Request fields are latched only at the IDLE→WRITE transition.
  - Deasserting `req` before it is latched withdraws the request with no effect.
  - Deasserting it after latching does not cancel the write.
- Bus writes from other masters are not observed; this block is the sole writer of the PIO.

## Timing
- Reset values (one cycle after `reset` sampled high):
  - `ack`=0, `err`=0, `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
  - `shadow`=0, `ptr`=0, state IDLE.
  - `shadow`=0 matches the PIO reset value.
- All outputs are registered.
- Latency: `req` sampled high in cycle N (block in IDLE) → WRITE in cycle N+1. In N+1, `m_chipselect`=1, `m_write_n`=0, address/data valid, and `ack` pulses. `shadow` shows the new value in N+2.
- The slave has no waitrequest; the write completes in the single WRITE cycle.
- Throughput: one write per 2 cycles. Continuous requests from all requesters are served in strict rotation; none waits more than 2×(NREQ−1) cycles after becoming eligible.
- A requester must drop `req` in the cycle after `ack`, otherwise it is re-arbitrated as a new request.
- Reset asserted during WRITE: the next cycle shows reset values, and no `ack` is issued for an unfinished grant.

## Structure
- Package `pio_arb_pkg`:
  - op encoding constants (`OP_WRITE`, `OP_SET`, `OP_CLR`, `OP_RSVD`);
  - address constants (`PIO_ADDR_DATA`=0, `PIO_ADDR_SET`=4, `PIO_ADDR_CLR`=5);
  - FSM state type.
- One sub-module, `rr_arbiter`, parameterised by NREQ. Inputs: `req` and `ptr`. Outputs: one-hot grant, encoded index, `any`. Purely combinational. The top level owns `ptr`, the FSM, the latches and the shadow.

## Test plan
- Reset then single write: req[0], op 00, data 17'h1A5A5. One cycle later: `m_address`=0, `m_writedata`=32'h0001A5A5, `m_write_n`=0, `ack`=0001. Then `shadow`=17'h1A5A5.
- Set/clear: from `shadow`=17'h000F0, req[1] set 17'h00003 → address 4, `shadow`=17'h000F3. Then req[2] clear 17'h00030 → address 5, `shadow`=17'h000C3.
- Fairness: all four `req` held high continuously (re-asserting after each ack) from `ptr`=0. Ack order is 0,1,2,3,0, with one ack every 2 cycles.
- Reserved op: req[3] op 11 → `ack`=1000 and `err`=1 in the same cycle, `m_chipselect` stays 0, `shadow` unchanged.
- Withdrawal and late drop:
  - req[2] raised and dropped while req[0] is being served → req[2] never acked.
  - req[1] dropped in its WRITE cycle → write still issued.
- Reset mid-operation: `reset` asserted in a WRITE cycle → next cycle `m_chipselect`=0, `m_write_n`=1, `shadow`=0, no `ack`.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO write arbiter: op encodings,
// PIO register addresses and the FSM state type.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [2:0] PIO_ADDR_DATA = 3'd0;
    localparam logic [2:0] PIO_ADDR_SET  = 3'd4;
    localparam logic [2:0] PIO_ADDR_CLR  = 3'd5;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    function automatic logic [2:0] op_addr(input op_e op);
        case (op)
            OP_SET:  return PIO_ADDR_SET;
            OP_CLR:  return PIO_ADDR_CLR;
            default: return PIO_ADDR_DATA;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam int unsigned N = NREQ;

    int unsigned     sum;
    logic [IW-1:0]   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr is always below NREQ, so one subtraction performs the wrap
            sum = 32'(ptr) + i;
            if (sum >= N) sum = sum - N;
            cand = IW'(sum);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Serialises write/set/clear requests from NREQ requesters into single-cycle
// Avalon-MM PIO writes and keeps a shadow of the PIO output value.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    output logic [2:0]               m_address,
    output logic                     m_chipselect,
    output logic                     m_write_n,
    output logic [31:0]              m_writedata,
    output logic [DATA_W-1:0]        shadow
);

    localparam int IW = $clog2(NREQ);

    logic [1:0]        op_arr   [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign data_arr[g] = req_data[DATA_W*g +: DATA_W];
    end

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    op_e               win_op;
    logic [DATA_W-1:0] win_data;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;

    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [2:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign win_op   = op_e'(op_arr[arb_idx]);
    assign win_data = data_arr[arb_idx];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_any) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are computed for the cycle being entered
    always_comb begin
        ack_d   = '0;
        err_d   = 1'b0;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = PIO_ADDR_DATA;
        wdata_d = '0;
        if (state_q == S_IDLE && arb_any) begin
            ack_d = arb_grant;
            err_d = (win_op == OP_RSVD);
            if (win_op != OP_RSVD) begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = op_addr(win_op);
                wdata_d = {{(32-DATA_W){1'b0}}, win_data};
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        op_d     = op_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        if (state_q == S_IDLE && arb_any) begin
            idx_d  = arb_idx;
            op_d   = win_op;
            data_d = win_data;
        end
        if (state_q == S_WRITE) begin
            ptr_d = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
            case (op_q)
                OP_WRITE: shadow_d = data_q;
                OP_SET:   shadow_d = shadow_q | data_q;
                OP_CLR:   shadow_d = shadow_q & ~data_q;
                default:  shadow_d = shadow_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            idx_q    <= '0;
            op_q     <= OP_WRITE;
            data_q   <= '0;
            shadow_q <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            addr_q   <= PIO_ADDR_DATA;
            wdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ack          = ack_q;
    assign err          = err_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign shadow       = shadow_q;

endmodule
